// File: rtl/ropuf_ctrl_if.sv
// ropuf_ctrl_if -- host-side handshake bundle for the RO PUF controller.
//
// Signals:
//   Start, Abort          host -> controller request / synchronous abort
//   BaseChallenge         first challenge of the sequence (NBITS_ROPUF)
//   WindowCycles          measurement window length in cycles (NBITS_WIN)
//   Busy                  controller -> host, high outside IDLE
//   RespValid, RespReady  response-word valid/ready handshake
//   Response              assembled response word (NBITS_RESP)
//
// Modports: master = host/consumer side, slave = controller side.
interface ropuf_ctrl_if #(
  parameter int NBITS_ROPUF = 8,
  parameter int NBITS_RESP  = 16,
  parameter int NBITS_WIN   = 8
);
  logic                   Start;
  logic                   Abort;
  logic [NBITS_ROPUF-1:0] BaseChallenge;
  logic [NBITS_WIN-1:0]   WindowCycles;
  logic                   Busy;
  logic                   RespValid;
  logic                   RespReady;
  logic [NBITS_RESP-1:0]  Response;

  modport master (
    output Start, Abort, BaseChallenge, WindowCycles, RespReady,
    input  Busy, RespValid, Response
  );

  modport slave (
    input  Start, Abort, BaseChallenge, WindowCycles, RespReady,
    output Busy, RespValid, Response
  );
endinterface

// File: rtl/ropuf_ctrl.sv
// ropuf_ctrl -- sequencer that builds an NBITS_RESP-bit response word from a
// ring-oscillator PUF, one evaluation (or three, majority voted) per bit.
//
// Ports:
//   Clock, Reset    system clock; asynchronous active-high reset
//   host            ropuf_ctrl_if.slave: Start/Abort/BaseChallenge/WindowCycles
//                   in, Busy/RespValid/Response out, RespReady in
//   PufEnable       enable to the RO PUF (registered)
//   PufReset        synchronous clear pulse to the RO PUF (registered)
//   PufChallenge    challenge applied to the RO PUF (registered)
//   PufResponse     response bit from the RO PUF
//
// Build option: define ROPUF_MAJORITY_EN to evaluate every challenge three
// times and take the majority; otherwise a single evaluation per bit.
//
// state   | meaning
// IDLE    | waiting for Start; Response holds last word
// SETUP   | challenge applied, PUF cleared (1 cycle)
// MEASURE | PUF enabled for W window cycles
// CAPTURE | PUF response sampled into the word (1 cycle)
// VALID   | response word presented until RespReady
module ropuf_ctrl #(
  parameter int NBITS_ROPUF = 8,
  parameter int NBITS_RESP  = 16,
  parameter int NBITS_WIN   = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  ropuf_ctrl_if.slave            host,
  output logic                   PufEnable,
  output logic                   PufReset,
  output logic [NBITS_ROPUF-1:0] PufChallenge,
  input  logic                   PufResponse
);
  localparam int KW = (NBITS_RESP > 1) ? $clog2(NBITS_RESP) : 1;
  localparam logic [KW-1:0] LAST_BIT = KW'(NBITS_RESP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, MEASURE, CAPTURE, VALID} state_t;

  state_t                 state, stateNext;
  logic [KW-1:0]          bitIdx, bitIdxNext;
  logic [NBITS_WIN-1:0]   winLen, winLenNext;
  logic [NBITS_WIN-1:0]   winCnt, winCntNext;
  logic [NBITS_ROPUF-1:0] base, baseNext;
  logic [NBITS_ROPUF-1:0] chal, chalNext;
  logic [NBITS_RESP-1:0]  resp, respNext;
  logic                   pufEn, pufEnNext;
  logic                   pufRst, pufRstNext;
  logic                   busyQ, busyNext;
  logic                   validQ, validNext;
  logic                   bitDone;
  logic                   bitVal;
`ifdef ROPUF_MAJORITY_EN
  logic [1:0]             voteCnt, voteNext;
  logic [1:0]             passCnt, passNext;
`endif

  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    winLenNext = winLen;
    winCntNext = winCnt;
    baseNext   = base;
    chalNext   = chal;
    respNext   = resp;
    pufEnNext  = pufEn;
    pufRstNext = pufRst;
    validNext  = validQ;
`ifdef ROPUF_MAJORITY_EN
    voteNext   = voteCnt;
    passNext   = passCnt;
    // third evaluation closes the bit; votes so far plus the live sample
    bitDone    = (passCnt == 2'd2);
    bitVal     = (({1'b0, voteCnt} + {2'b00, PufResponse}) >= 3'd2);
`else
    bitDone    = 1'b1;
    bitVal     = PufResponse;
`endif

    case (state)
      IDLE: begin
        if (host.Start) begin
          baseNext   = host.BaseChallenge;
          winLenNext = (host.WindowCycles == '0) ? NBITS_WIN'(1) : host.WindowCycles;
          bitIdxNext = '0;
          respNext   = '0;
          chalNext   = host.BaseChallenge;
          pufRstNext = 1'b1;
          pufEnNext  = 1'b0;
          stateNext  = SETUP;
`ifdef ROPUF_MAJORITY_EN
          voteNext   = 2'd0;
          passNext   = 2'd0;
`endif
        end
      end
      SETUP: begin
        pufRstNext = 1'b0;
        pufEnNext  = 1'b1;
        winCntNext = winLen - NBITS_WIN'(1);
        stateNext  = MEASURE;
      end
      MEASURE: begin
        if (winCnt == '0) begin
          pufEnNext = 1'b0;
          stateNext = CAPTURE;
        end else begin
          winCntNext = winCnt - NBITS_WIN'(1);
        end
      end
      CAPTURE: begin
        if (!bitDone) begin
`ifdef ROPUF_MAJORITY_EN
          voteNext = voteCnt + {1'b0, PufResponse};
          passNext = passCnt + 2'd1;
`endif
          pufRstNext = 1'b1;
          stateNext  = SETUP;
        end else begin
          respNext[bitIdx] = bitVal;
`ifdef ROPUF_MAJORITY_EN
          voteNext = 2'd0;
          passNext = 2'd0;
`endif
          if (bitIdx == LAST_BIT) begin
            validNext = 1'b1;
            stateNext = VALID;
          end else begin
            bitIdxNext = bitIdx + KW'(1);
            // challenge wraps naturally at NBITS_ROPUF bits
            chalNext   = base + NBITS_ROPUF'(bitIdxNext);
            pufRstNext = 1'b1;
            stateNext  = SETUP;
          end
        end
      end
      VALID: begin
        if (host.RespReady) begin
          validNext = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Abort wins over Start and RespReady from every state
    if (host.Abort) begin
      stateNext  = IDLE;
      pufEnNext  = 1'b0;
      pufRstNext = 1'b0;
      validNext  = 1'b0;
      respNext   = '0;
      bitIdxNext = '0;
`ifdef ROPUF_MAJORITY_EN
      voteNext   = 2'd0;
      passNext   = 2'd0;
`endif
    end

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      bitIdx <= '0;
      winLen <= '0;
      winCnt <= '0;
      base   <= '0;
      chal   <= '0;
      resp   <= '0;
      pufEn  <= 1'b0;
      pufRst <= 1'b0;
      busyQ  <= 1'b0;
      validQ <= 1'b0;
`ifdef ROPUF_MAJORITY_EN
      voteCnt <= 2'd0;
      passCnt <= 2'd0;
`endif
    end else begin
      state  <= stateNext;
      bitIdx <= bitIdxNext;
      winLen <= winLenNext;
      winCnt <= winCntNext;
      base   <= baseNext;
      chal   <= chalNext;
      resp   <= respNext;
      pufEn  <= pufEnNext;
      pufRst <= pufRstNext;
      busyQ  <= busyNext;
      validQ <= validNext;
`ifdef ROPUF_MAJORITY_EN
      voteCnt <= voteNext;
      passCnt <= passNext;
`endif
    end
  end

  assign PufEnable      = pufEn;
  assign PufReset       = pufRst;
  assign PufChallenge   = chal;
  assign host.Busy      = busyQ;
  assign host.RespValid = validQ;
  assign host.Response  = resp;
endmodule

// File: tb/tb_ropuf_ctrl.sv
module tb_ropuf_ctrl;
  localparam int NR = 8;
  localparam int NRESP = 16;
  localparam int NW = 8;
`ifdef ROPUF_MAJORITY_EN
  localparam int EVALS = 3;
`else
  localparam int EVALS = 1;
`endif

  logic Clock = 1'b0;
  logic Reset;
  logic PufEnable, PufReset, PufResponse;
  logic [NR-1:0] PufChallenge;

  ropuf_ctrl_if #(.NBITS_ROPUF(NR), .NBITS_RESP(NRESP), .NBITS_WIN(NW)) host();

  ropuf_ctrl #(.NBITS_ROPUF(NR), .NBITS_RESP(NRESP), .NBITS_WIN(NW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .host(host),
    .PufEnable(PufEnable),
    .PufReset(PufReset),
    .PufChallenge(PufChallenge),
    .PufResponse(PufResponse)
  );

  always #5 Clock = ~Clock;

  int compared = 0;
  int mismatched = 0;

  // PUF stub: parity of the challenge, or a scripted per-evaluation sequence
  int stubMode = 0;
  int evalIdx = 0;
  logic evalClear = 1'b0;
  int script [12] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
  logic [NR-1:0] chalLog [64];

  always @(posedge Clock) begin
    if (evalClear) evalIdx <= 0;
    else if (PufReset) evalIdx <= evalIdx + 1;
  end

  always_comb begin
    PufResponse = ^PufChallenge;
    if (stubMode == 1) begin
      PufResponse = 1'b0;
      if (evalIdx >= 1 && evalIdx <= 12) PufResponse = (script[evalIdx-1] != 0);
    end
  end

  task automatic run_word(input logic [NR-1:0] base, input logic [NW-1:0] win,
                          input bit pulseStart, output int lat, output int setups,
                          output int enCycles, output logic [NRESP-1:0] resp);
    host.BaseChallenge = base;
    host.WindowCycles = win;
    host.Start = 1'b1;
    @(posedge Clock); #1;
    host.Start = 1'b0;
    lat = 0; setups = 0; enCycles = 0;
    while (lat < 400) begin
      if (host.RespValid) break;
      if (PufReset) begin
        if (setups < 64) chalLog[setups] = PufChallenge;
        setups++;
      end
      if (PufEnable) enCycles++;
      if (pulseStart) host.Start = (lat == 10 || lat == 30);
      @(posedge Clock); #1;
      lat++;
    end
    host.Start = 1'b0;
    resp = host.Response;
  endtask

  task automatic release_word();
    host.RespReady = 1'b1;
    @(posedge Clock); #1;
    host.RespReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    host.Start = 1'b0; host.Abort = 1'b0; host.RespReady = 1'b0;
    host.BaseChallenge = '0; host.WindowCycles = '0;
    repeat (3) @(posedge Clock);
    #3 Reset = 1'b0;
    @(posedge Clock); #1;
    compared++; if (host.Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", host.Busy); end
    compared++; if (host.RespValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got=%b exp=0", host.RespValid); end
    compared++; if (host.Response !== 16'h0000) begin mismatched++; $display("FAIL reset_resp got=%h exp=0000", host.Response); end
    compared++; if (PufEnable !== 1'b0) begin mismatched++; $display("FAIL reset_en got=%b exp=0", PufEnable); end
    compared++; if (PufReset !== 1'b0) begin mismatched++; $display("FAIL reset_pufrst got=%b exp=0", PufReset); end
    compared++; if (PufChallenge !== 8'h00) begin mismatched++; $display("FAIL reset_chal got=%h exp=00", PufChallenge); end
  endtask

  task automatic test_basic();
    int lat, setups, en;
    logic [NRESP-1:0] r;
    logic [NR-1:0] e;
    run_word(8'h10, 8'd4, 1'b0, lat, setups, en, r);
    compared++; if (lat !== 16*EVALS*6) begin mismatched++; $display("FAIL basic_latency got=%0d exp=%0d", lat, 16*EVALS*6); end
    compared++; if (r !== 16'h9669) begin mismatched++; $display("FAIL basic_resp got=%h exp=9669", r); end
    compared++; if (setups !== 16*EVALS) begin mismatched++; $display("FAIL basic_setups got=%0d exp=%0d", setups, 16*EVALS); end
    compared++; if (en !== 16*EVALS*4) begin mismatched++; $display("FAIL basic_en_cycles got=%0d exp=%0d", en, 16*EVALS*4); end
    for (int i = 0; i < 16*EVALS; i++) begin
      e = 8'h10 + 8'(i / EVALS);
      compared++; if (chalLog[i] !== e) begin mismatched++; $display("FAIL basic_chal[%0d] got=%h exp=%h", i, chalLog[i], e); end
    end
    release_word();
    compared++; if (host.RespValid !== 1'b0) begin mismatched++; $display("FAIL basic_release got=%b exp=0", host.RespValid); end
  endtask

  task automatic test_wrap();
    int lat, setups, en;
    logic [NRESP-1:0] r;
    logic [NR-1:0] e;
    run_word(8'hF8, 8'd0, 1'b0, lat, setups, en, r);
    compared++; if (lat !== 16*EVALS*3) begin mismatched++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, 16*EVALS*3); end
    compared++; if (r !== 16'h9669) begin mismatched++; $display("FAIL wrap_resp got=%h exp=9669", r); end
    compared++; if (en !== 16*EVALS) begin mismatched++; $display("FAIL wrap_en_cycles got=%0d exp=%0d", en, 16*EVALS); end
    for (int i = 0; i < 16*EVALS; i++) begin
      e = 8'hF8 + 8'(i / EVALS);
      compared++; if (chalLog[i] !== e) begin mismatched++; $display("FAIL wrap_chal[%0d] got=%h exp=%h", i, chalLog[i], e); end
    end
    release_word();
  endtask

  task automatic test_handshake();
    int lat, setups, en;
    logic [NRESP-1:0] r;
    run_word(8'h03, 8'd1, 1'b1, lat, setups, en, r);
    compared++; if (lat !== 16*EVALS*3) begin mismatched++; $display("FAIL hs_latency got=%0d exp=%0d", lat, 16*EVALS*3); end
    compared++; if (r !== 16'h2D32) begin mismatched++; $display("FAIL hs_resp got=%h exp=2D32", r); end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      compared++; if (host.RespValid !== 1'b1) begin mismatched++; $display("FAIL hs_hold_valid[%0d] got=%b exp=1", i, host.RespValid); end
      compared++; if (host.Response !== 16'h2D32) begin mismatched++; $display("FAIL hs_hold_resp[%0d] got=%h exp=2D32", i, host.Response); end
    end
    host.RespReady = 1'b1;
    host.Start = 1'b1;
    host.BaseChallenge = 8'h20;
    host.WindowCycles = 8'd3;
    @(posedge Clock); #1;
    host.RespReady = 1'b0;
    compared++; if (host.RespValid !== 1'b0) begin mismatched++; $display("FAIL hs_valid_drop got=%b exp=0", host.RespValid); end
    compared++; if (host.Busy !== 1'b0) begin mismatched++; $display("FAIL hs_idle_busy got=%b exp=0", host.Busy); end
    compared++; if (host.Response !== 16'h2D32) begin mismatched++; $display("FAIL hs_idle_hold got=%h exp=2D32", host.Response); end
    @(posedge Clock); #1;
    host.Start = 1'b0;
    compared++; if (host.Busy !== 1'b1) begin mismatched++; $display("FAIL hs_restart_busy got=%b exp=1", host.Busy); end
    compared++; if (PufReset !== 1'b1) begin mismatched++; $display("FAIL hs_restart_setup got=%b exp=1", PufReset); end
    compared++; if (PufChallenge !== 8'h20) begin mismatched++; $display("FAIL hs_restart_chal got=%h exp=20", PufChallenge); end
    host.Abort = 1'b1;
    @(posedge Clock); #1;
    host.Abort = 1'b0;
  endtask

  task automatic test_abort();
    int seen = 0;
    host.BaseChallenge = 8'h10; host.WindowCycles = 8'd4; host.Start = 1'b1;
    @(posedge Clock); #1;
    host.Start = 1'b0;
    repeat (19) @(posedge Clock);
    #1 host.Abort = 1'b1;
    @(posedge Clock); #1;
    host.Abort = 1'b0;
    compared++; if (host.Busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy got=%b exp=0", host.Busy); end
    compared++; if (PufEnable !== 1'b0) begin mismatched++; $display("FAIL abort_en got=%b exp=0", PufEnable); end
    compared++; if (PufReset !== 1'b0) begin mismatched++; $display("FAIL abort_pufrst got=%b exp=0", PufReset); end
    compared++; if (host.Response !== 16'h0000) begin mismatched++; $display("FAIL abort_resp got=%h exp=0000", host.Response); end
    host.Abort = 1'b1; host.Start = 1'b1;
    @(posedge Clock); #1;
    host.Abort = 1'b0; host.Start = 1'b0;
    compared++; if (host.Busy !== 1'b0) begin mismatched++; $display("FAIL abort_prio_busy got=%b exp=0", host.Busy); end
    for (int i = 0; i < 120; i++) begin
      @(posedge Clock); #1;
      if (host.RespValid) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat, setups, en;
    logic [NRESP-1:0] r;
    host.BaseChallenge = 8'h10; host.WindowCycles = 8'd4; host.Start = 1'b1;
    @(posedge Clock); #1;
    host.Start = 1'b0;
    repeat (19) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    compared++; if (host.Busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy got=%b exp=0", host.Busy); end
    compared++; if (PufEnable !== 1'b0) begin mismatched++; $display("FAIL rstmid_en got=%b exp=0", PufEnable); end
    compared++; if (host.Response !== 16'h0000) begin mismatched++; $display("FAIL rstmid_resp got=%h exp=0000", host.Response); end
    compared++; if (PufChallenge !== 8'h00) begin mismatched++; $display("FAIL rstmid_chal got=%h exp=00", PufChallenge); end
    #2 Reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge Clock); #1;
      if (host.RespValid) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL rstmid_no_valid got=%0d exp=0", seen); end
    run_word(8'h10, 8'd4, 1'b0, lat, setups, en, r);
    compared++; if (lat !== 16*EVALS*6) begin mismatched++; $display("FAIL rstmid_relat got=%0d exp=%0d", lat, 16*EVALS*6); end
    compared++; if (r !== 16'h9669) begin mismatched++; $display("FAIL rstmid_reresp got=%h exp=9669", r); end
    release_word();
  endtask

`ifdef ROPUF_MAJORITY_EN
  task automatic test_majority();
    int lat, setups, en;
    logic [NRESP-1:0] r;
    stubMode = 1;
    evalClear = 1'b1;
    @(posedge Clock); #1;
    evalClear = 1'b0;
    run_word(8'h40, 8'd2, 1'b0, lat, setups, en, r);
    compared++; if (lat !== 192) begin mismatched++; $display("FAIL maj_latency got=%0d exp=192", lat); end
    compared++; if (r !== 16'h0005) begin mismatched++; $display("FAIL maj_resp got=%h exp=0005", r); end
    compared++; if (setups !== 48) begin mismatched++; $display("FAIL maj_setups got=%0d exp=48", setups); end
    release_word();
    stubMode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_handshake();
    test_abort();
    test_reset_mid();
`ifdef ROPUF_MAJORITY_EN
    test_majority();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
